exact_mult_slot_scheduler: RTL and testbench

- Upstream control stage for a PE triplet.
- Generates the slot counter `counter_for_exact_mult_usage` in the fast_clk domain and phase-locks it to the slow clk, which runs at 1/3 the fast rate.
- Owns the single shared exact HALFxHALF multiplier and time-multiplexes it among PE0/PE1/PE2: one slot per fast_clk cycle, three slots per slow clk cycle.
- Each PE consumes the registered high-part product during its slot.

---
 rtl/exact_mult_slot_scheduler_if.sv | 38 +++
 rtl/exact_mult_slot_scheduler.sv | 141 ++++++++++++++
 tb/tb_exact_mult_slot_scheduler.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/exact_mult_slot_scheduler_if.sv
// rtl/exact_mult_slot_scheduler_if.sv - operand/result bundle between the slow domain, the PE triplet and the slot scheduler
interface exact_mult_slot_scheduler_if #(
    parameter int HALF = 4
);
    logic              slow_toggle;
    logic              clear_err;
    logic [HALF-1:0]   aH0;
    logic [HALF-1:0]   bH0;
    logic [HALF-1:0]   aH1;
    logic [HALF-1:0]   bH1;
    logic [HALF-1:0]   aH2;
    logic [HALF-1:0]   bH2;
    logic [1:0]        counter_for_exact_mult_usage;
    logic              frame_start;
    logic [2*HALF-1:0] exact_result;
    logic              result_valid;
    logic [2:0]        result_sel;
    logic              locked;
    logic              sync_err;

    // Slow domain / PE side: supplies operands and the phase toggle.
    modport master (
        output slow_toggle, clear_err,
        output aH0, bH0, aH1, bH1, aH2, bH2,
        input  counter_for_exact_mult_usage, frame_start,
        input  exact_result, result_valid, result_sel,
        input  locked, sync_err
    );

    // Scheduler side: owns the slot counter and the shared multiplier.
    modport slave (
        input  slow_toggle, clear_err,
        input  aH0, bH0, aH1, bH1, aH2, bH2,
        output counter_for_exact_mult_usage, frame_start,
        output exact_result, result_valid, result_sel,
        output locked, sync_err
    );
endinterface

// File: rtl/exact_mult_slot_scheduler.sv
// rtl/exact_mult_slot_scheduler.sv - phase-locked slot counter time-sharing one exact HALFxHALF multiplier across three PEs
module exact_mult_slot_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int HALF       = DATA_WIDTH / 2,
    parameter int SIGNED_OPS = 0
) (
    input  logic fast_clk,
    input  logic rst,
    exact_mult_slot_scheduler_if.slave sched
);
    // Sign-extend the operands only for signed builds; the low 2*HALF bits
    // of the extended product are then exact for either signedness.
    localparam bit SEXT = (SIGNED_OPS != 0);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q;
    logic [1:0]        counter_q;
    logic              toggle_q;
    logic              frame_start_q;
    logic [2*HALF-1:0] exact_result_q;
    logic              result_valid_q;
    logic [2:0]        result_sel_q;
    logic              locked_q;
    logic              sync_err_q;

    logic              chg;
    logic              slip;
    logic [HALF-1:0]   op_a;
    logic [HALF-1:0]   op_b;
    logic [2*HALF-1:0] a_ext;
    logic [2*HALF-1:0] b_ext;
    logic [2*HALF-1:0] prod_d;
    logic [2:0]        sel_d;

    assign chg = sched.slow_toggle ^ toggle_q;

    // A slip is a toggle that arrives off slot 3, or slot 3 passing without one.
    assign slip = (state_q == RUN) &&
                  ((chg && (counter_q != 2'd3)) || (!chg && (counter_q == 2'd3)));

    // Route the current slot owner's operands into the shared multiplier.
    always_comb begin
        op_a  = sched.aH0;
        op_b  = sched.bH0;
        sel_d = 3'b000;
        case (counter_q)
            2'd1: begin
                op_a  = sched.aH0;
                op_b  = sched.bH0;
                sel_d = 3'b001;
            end
            2'd2: begin
                op_a  = sched.aH1;
                op_b  = sched.bH1;
                sel_d = 3'b010;
            end
            2'd3: begin
                op_a  = sched.aH2;
                op_b  = sched.bH2;
                sel_d = 3'b100;
            end
            default: begin
                op_a  = sched.aH0;
                op_b  = sched.bH0;
                sel_d = 3'b000;
            end
        endcase
        a_ext  = {{HALF{SEXT & op_a[HALF-1]}}, op_a};
        b_ext  = {{HALF{SEXT & op_b[HALF-1]}}, op_b};
        prod_d = a_ext * b_ext;
    end

    // Lock FSM, slot counter, shared product register and sticky slip flag.
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            counter_q      <= 2'd0;
            toggle_q       <= 1'b0;
            frame_start_q  <= 1'b0;
            exact_result_q <= '0;
            result_valid_q <= 1'b0;
            result_sel_q   <= 3'b000;
            locked_q       <= 1'b0;
            sync_err_q     <= 1'b0;
        end else begin
            toggle_q <= sched.slow_toggle;

            if (slip) begin
                sync_err_q <= 1'b1;
            end else if (sched.clear_err) begin
                sync_err_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    result_valid_q <= 1'b0;
                    result_sel_q   <= 3'b000;
                    if (chg) begin
                        state_q       <= RUN;
                        counter_q     <= 2'd1;
                        frame_start_q <= 1'b1;
                        locked_q      <= 1'b1;
                    end else begin
                        counter_q     <= 2'd0;
                        frame_start_q <= 1'b0;
                        locked_q      <= 1'b0;
                    end
                end
                RUN: begin
                    exact_result_q <= prod_d;
                    result_valid_q <= 1'b1;
                    result_sel_q   <= sel_d;
                    locked_q       <= 1'b1;
                    // Any toggle, or the end of slot 3, restarts the frame at slot 1.
                    if (chg || (counter_q == 2'd3)) begin
                        counter_q     <= 2'd1;
                        frame_start_q <= 1'b1;
                    end else begin
                        counter_q     <= counter_q + 2'd1;
                        frame_start_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sched.counter_for_exact_mult_usage = counter_q;
    assign sched.frame_start                  = frame_start_q;
    assign sched.exact_result                 = exact_result_q;
    assign sched.result_valid                 = result_valid_q;
    assign sched.result_sel                   = result_sel_q;
    assign sched.locked                       = locked_q;
    assign sched.sync_err                     = sync_err_q;
endmodule

// File: tb/tb_exact_mult_slot_scheduler.sv
// tb/tb_exact_mult_slot_scheduler.sv - directed self-checking bench for exact_mult_slot_scheduler
module tb_exact_mult_slot_scheduler;
    logic fast_clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    exact_mult_slot_scheduler_if #(.HALF(4)) if_u ();
    exact_mult_slot_scheduler_if #(.HALF(4)) if_s ();

    // The signed build sees exactly the same stimulus as the unsigned one.
    assign if_s.slow_toggle = if_u.slow_toggle;
    assign if_s.clear_err   = if_u.clear_err;
    assign if_s.aH0         = if_u.aH0;
    assign if_s.bH0         = if_u.bH0;
    assign if_s.aH1         = if_u.aH1;
    assign if_s.bH1         = if_u.bH1;
    assign if_s.aH2         = if_u.aH2;
    assign if_s.bH2         = if_u.bH2;

    exact_mult_slot_scheduler #(.DATA_WIDTH(8), .SIGNED_OPS(0)) u_dut_u (
        .fast_clk (fast_clk),
        .rst      (rst),
        .sched    (if_u.slave)
    );

    exact_mult_slot_scheduler #(.DATA_WIDTH(8), .SIGNED_OPS(1)) u_dut_s (
        .fast_clk (fast_clk),
        .rst      (rst),
        .sched    (if_s.slave)
    );

    initial fast_clk = 1'b0;
    always #5 fast_clk = ~fast_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " counter"}, 32'(if_u.counter_for_exact_mult_usage), 32'd0);
        check({tag, " frame"},   32'(if_u.frame_start),  32'd0);
        check({tag, " result"},  32'(if_u.exact_result), 32'd0);
        check({tag, " valid"},   32'(if_u.result_valid), 32'd0);
        check({tag, " sel"},     32'(if_u.result_sel),   32'd0);
        check({tag, " locked"},  32'(if_u.locked),       32'd0);
        check({tag, " syncerr"}, 32'(if_u.sync_err),     32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        if_u.slow_toggle = 1'b0;
        if_u.clear_err   = 1'b0;
        if_u.aH0 = 4'd0; if_u.bH0 = 4'd0;
        if_u.aH1 = 4'd0; if_u.bH1 = 4'd0;
        if_u.aH2 = 4'd0; if_u.bH2 = 4'd0;

        // Reset state, then idle with no toggle.
        tick();
        tick();
        check_reset_outputs("in_reset");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_reset_outputs("idle10");

        // Lock on the first toggle, then 20 clean frames.
        if_u.slow_toggle = ~if_u.slow_toggle;
        tick();
        check("lock counter", 32'(if_u.counter_for_exact_mult_usage), 32'd1);
        check("lock locked",  32'(if_u.locked), 32'd1);
        for (int f = 0; f < 20; f++) begin
            check("run c1",  32'(if_u.counter_for_exact_mult_usage), 32'd1);
            check("run fs1", 32'(if_u.frame_start), 32'd1);
            tick();
            check("run c2",  32'(if_u.counter_for_exact_mult_usage), 32'd2);
            check("run fs2", 32'(if_u.frame_start), 32'd0);
            tick();
            check("run c3",  32'(if_u.counter_for_exact_mult_usage), 32'd3);
            check("run fs3", 32'(if_u.frame_start), 32'd0);
            if_u.slow_toggle = ~if_u.slow_toggle;
            tick();
        end
        check("run syncerr", 32'(if_u.sync_err), 32'd0);
        check("run locked",  32'(if_u.locked), 32'd1);

        // Products for the three slots, counter now at 1.
        if_u.aH0 = 4'd5; if_u.bH0 = 4'd4;
        if_u.aH1 = 4'd5; if_u.bH1 = 4'd4;
        if_u.aH2 = 4'd6; if_u.bH2 = 4'd5;
        tick();
        check("pe0 result", 32'(if_u.exact_result), 32'd20);
        check("pe0 sel",    32'(if_u.result_sel),   32'b001);
        check("pe0 valid",  32'(if_u.result_valid), 32'd1);
        tick();
        check("pe1 result", 32'(if_u.exact_result), 32'd20);
        check("pe1 sel",    32'(if_u.result_sel),   32'b010);
        if_u.slow_toggle = ~if_u.slow_toggle;
        tick();
        check("pe2 result",   32'(if_u.exact_result), 32'd30);
        check("pe2 sel",      32'(if_u.result_sel),   32'b100);
        check("pe2 s result", 32'(if_s.exact_result), 32'd30);
        check("pe2 syncerr",  32'(if_u.sync_err),     32'd0);

        // Signedness: 4'hB * 4'h4.
        if_u.aH0 = 4'hB; if_u.bH0 = 4'h4;
        tick();
        check("unsigned B*4", 32'(if_u.exact_result), 32'h2C);
        check("signed B*4",   32'(if_s.exact_result), 32'hEC);
        check("pre slip c2",  32'(if_u.counter_for_exact_mult_usage), 32'd2);

        // Early toggle at slot 2.
        if_u.slow_toggle = ~if_u.slow_toggle;
        tick();
        check("slip syncerr", 32'(if_u.sync_err), 32'd1);
        check("slip counter", 32'(if_u.counter_for_exact_mult_usage), 32'd1);
        check("slip frame",   32'(if_u.frame_start), 32'd1);

        // Clear together with a second slip: set wins.
        if_u.slow_toggle = ~if_u.slow_toggle;
        if_u.clear_err   = 1'b1;
        tick();
        check("slip2 syncerr", 32'(if_u.sync_err), 32'd1);
        check("slip2 counter", 32'(if_u.counter_for_exact_mult_usage), 32'd1);
        check("slip2 frame",   32'(if_u.frame_start), 32'd1);

        // Clear alone.
        tick();
        if_u.clear_err = 1'b0;
        check("clear syncerr", 32'(if_u.sync_err), 32'd0);
        check("clear counter", 32'(if_u.counter_for_exact_mult_usage), 32'd2);

        // Missing toggle at slot 3.
        tick();
        check("miss c3", 32'(if_u.counter_for_exact_mult_usage), 32'd3);
        tick();
        check("miss syncerr", 32'(if_u.sync_err), 32'd1);
        check("miss counter", 32'(if_u.counter_for_exact_mult_usage), 32'd1);
        if_u.clear_err = 1'b1;
        tick();
        if_u.clear_err = 1'b0;
        check("miss clear", 32'(if_u.sync_err), 32'd0);
        check("pre rst c2", 32'(if_u.counter_for_exact_mult_usage), 32'd2);

        // Asynchronous reset mid-cycle while counter is 2.
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("post rst idle", 32'(if_u.counter_for_exact_mult_usage), 32'd0);
        if_u.slow_toggle = ~if_u.slow_toggle;
        tick();
        check("relock counter", 32'(if_u.counter_for_exact_mult_usage), 32'd1);
        check("relock locked",  32'(if_u.locked), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
